// File: rtl/fsm_recv_logic.sv
// fsm_recv_logic: receives one fixed-length burst over send_req/send_done and drains it over valid/ready
module fsm_recv_logic #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 9,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  send_req,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  send_done,
   output logic                  recv_abort,
   output logic                  receiving,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);
   typedef enum logic [1:0] {IDLE, RECV, DONE, DRAIN} state_t;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BURST_LEN - 1);
   state_t state, state_nx;
   logic [CNT_WIDTH-1:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
   logic [DATA_WIDTH-1:0] buffer [BURST_LEN];
   logic wr_en;
   assign wr_en      = state == RECV && send_req && in_valid;
   assign receiving  = state == RECV;
   assign send_done  = state == DONE;
   assign recv_abort = state == RECV && !send_req;
   assign out_valid  = state == DRAIN;
   assign out_data   = out_valid ? buffer[rd_ptr] : '0;
   always_comb begin
      state_nx = state;
      wr_nx    = wr_ptr;
      rd_nx    = rd_ptr;
      case (state)
         IDLE: if (send_req) begin
            state_nx = RECV;
            wr_nx    = '0;
         end
         RECV: if (!send_req) begin
            state_nx = IDLE;
            wr_nx    = '0;
         end else if (in_valid) begin
            state_nx = wr_ptr == LAST ? DONE : RECV;
            wr_nx    = wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
         end
         DONE: begin
            state_nx = DRAIN;
            rd_nx    = '0;
         end
         DRAIN: if (out_ready) begin
            state_nx = rd_ptr == LAST ? IDLE : DRAIN;
            rd_nx    = rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
         end
         default: begin
            state_nx = IDLE;
            wr_nx    = '0;
            rd_nx    = '0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state  <= state_nx;
         wr_ptr <= wr_nx;
         rd_ptr <= rd_nx;
      end
   end
   // Buffer has no reset; contents are only visible in DRAIN after a full burst.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) buffer[wr_ptr] <= in_data;
   end
endmodule

// File: tb/tb_fsm_recv_logic.sv
// tb_fsm_recv_logic: directed bench with an output scoreboard for fsm_recv_logic
module tb_fsm_recv_logic;
   logic clk = 1'b0;
   logic rst, send_req, in_valid, out_ready;
   logic [7:0] in_data;
   logic send_done, recv_abort, receiving, out_valid;
   logic [7:0] out_data;
   logic [7:0] q[$];
   int total = 0;
   int bad = 0;

   fsm_recv_logic #(.DATA_WIDTH(8), .BURST_LEN(9), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .send_req(send_req), .in_data(in_data), .in_valid(in_valid),
      .send_done(send_done), .recv_abort(recv_abort), .receiving(receiving),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic burst(input logic [7:0] base, input bit gaps, input bit keep);
      @(negedge clk);
      send_req = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("idle_receiving", receiving, 0);
      chk("idle_out_valid", out_valid, 0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'(base + i);
         q.push_back(8'(base + i));
         #1;
         chk("recv_receiving", receiving, 1);
         chk("recv_no_done", send_done, 0);
         if (gaps && i < 8) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'hEE;
            #1;
            chk("gap_receiving", receiving, 1);
            chk("gap_no_done", send_done, 0);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("done_pulse", send_done, 1);
      chk("done_receiving", receiving, 0);
      chk("done_out_valid", out_valid, 0);
      send_req = keep;
   endtask

   task automatic drain(input int stop, input bit stall);
      int idx = 0;
      int g = 0;
      int st = 0;
      logic [7:0] exp;
      while (idx < stop && g < 64) begin
         @(negedge clk);
         out_ready = !(stall && idx == 3 && st < 5);
         #1;
         chk("drain_valid", out_valid, 1);
         chk("drain_no_done", send_done, 0);
         if (!out_ready) begin
            chk("stall_data", out_data, q[0]);
            st++;
         end else begin
            exp = q.size() > 0 ? q.pop_front() : 8'hxx;
            chk("drain_data", out_data, exp);
            idx++;
         end
         g++;
      end
      out_ready = 1'b1;
      chk("drain_count", idx, stop);
      if (stall) chk("stall_cycles", st, 5);
   endtask

   initial begin
      rst = 1'b1; send_req = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_send_done", send_done, 0);
      chk("rst_abort", recv_abort, 0);
      chk("rst_receiving", receiving, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      // nominal, gapped input, then backpressure at word 3
      burst(8'h10, 1'b0, 1'b0);
      drain(9, 1'b0);
      burst(8'hA0, 1'b1, 1'b0);
      drain(9, 1'b0);
      burst(8'h10, 1'b0, 1'b0);
      drain(9, 1'b1);
      // abort after 4 words, the 5th word arrives with send_req low
      @(negedge clk);
      send_req = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("abort_idle", receiving, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'(8'h50 + i);
         #1;
         chk("abort_recv", receiving, 1);
      end
      @(negedge clk);
      send_req = 1'b0;
      in_data  = 8'hFF;
      #1;
      chk("abort_pulse", recv_abort, 1);
      chk("abort_no_done", send_done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk("abort_clear", recv_abort, 0);
         chk("abort_no_done2", send_done, 0);
         chk("abort_no_valid", out_valid, 0);
         chk("abort_idle2", receiving, 0);
      end
      burst(8'h20, 1'b0, 1'b0);
      drain(9, 1'b0);
      // back-to-back with send_req held through DRAIN
      burst(8'h60, 1'b0, 1'b1);
      drain(9, 1'b0);
      burst(8'h70, 1'b0, 1'b0);
      drain(9, 1'b0);
      // reset in DRAIN at rd_ptr=5
      burst(8'h30, 1'b0, 1'b0);
      drain(5, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_done", send_done, 0);
      chk("mid_rst_recv", receiving, 0);
      chk("mid_rst_data", out_data, 0);
      q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_valid", out_valid, 0);
         chk("post_rst_abort", recv_abort, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fsm_recv_logic.md
Name: fsm_recv_logic

Overview:
- Receiving end of the send_req/send_done burst handshake used between median-filter dataflow actors.
- Accepts one fixed-length burst of pixel words while the upstream sender holds send_req, then pulses send_done to release the sender.
- Buffers the burst in a small register array and drains it downstream over a valid/ready port.
- Refuses a new burst until the buffer has fully drained.

Parameters:
- DATA_WIDTH, 8: pixel word width in bits.
- BURST_LEN, 9: words per burst (3x3 median window); legal range 2..16.
- CNT_WIDTH, 4: width of the word pointers; must satisfy 2^CNT_WIDTH >= BURST_LEN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- send_req  in  1  sender requests or holds a burst transfer.
- in_data  in  DATA_WIDTH  burst word.
- in_valid  in  1  in_data is valid this cycle.
- send_done  out  1  one-cycle pulse: burst fully received.
- recv_abort  out  1  one-cycle pulse: send_req dropped before the burst completed.
- receiving  out  1  high while in RECV.
- out_data  out  DATA_WIDTH  buffered word at rd_ptr.
- out_valid  out  1  out_data is valid (DRAIN state).
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, wr_ptr=0, rd_ptr=0.
- Reset values of outputs: send_done=0, recv_abort=0, receiving=0, out_valid=0, out_data=0.
- Buffer contents are not reset. out_data is forced to 0 outside DRAIN.
- Reset mid-burst or mid-drain discards all data, with no send_done and no abort pulse.
- States are IDLE, RECV, DONE, DRAIN. The state register and pointers are registered. Outputs decode combinationally from state.
- IDLE:
  - send_req=1 -> RECV next cycle; wr_ptr=0.
  - in_valid is ignored.
- RECV (receiving=1):
  - Each cycle with in_valid=1 writes buffer[wr_ptr]=in_data and increments wr_ptr.
  - When in_valid=1 and wr_ptr==BURST_LEN-1, the word is written and the state goes to DONE next cycle.
  - in_valid=0 holds the state and pointers; gaps are allowed.
  - send_req=0 while in RECV: word writes stop, the state goes to IDLE next cycle, wr_ptr clears, and recv_abort pulses for one cycle (asserted combinationally in RECV while send_req=0).
  - If send_req=0 and in_valid=1 occur in the same cycle, the abort wins and the word is dropped.
- DONE:
  - send_done=1 for exactly one cycle, then DRAIN.
  - rd_ptr=0 on entry to DRAIN.
  - send_req and in_valid are ignored; the sender is expected to drop send_req on the following cycle.
- DRAIN:
  - out_valid=1 and out_data=buffer[rd_ptr].
  - A transfer occurs when out_valid and out_ready are both 1; rd_ptr then increments.
  - A transfer at rd_ptr==BURST_LEN-1 -> IDLE next cycle.
  - out_ready=0 holds out_data stable.
  - send_req and in_valid are ignored. A send_req held high across the DRAIN->IDLE edge is accepted one cycle later (IDLE->RECV).
- Latency:
  - Last input word to send_done: 1 cycle.
  - send_done to first out_valid: 1 cycle.
  - Minimum burst period with out_ready tied high: 1 (IDLE) + BURST_LEN + 1 (DONE) + BURST_LEN cycles.
- Word order out equals word order in. No reordering and no duplication.
- Pointers never exceed BURST_LEN-1. There is no wrap; each pointer clears on its phase entry.
- Unused state encodings -> IDLE.

Test Plan:
- Nominal:
  - Stimulus: send_req=1, in_valid=1 for 9 cycles with data 0x10..0x18; out_ready=1.
  - Required: receiving=1 for 9 cycles, send_done pulses once on the cycle after 0x18, then out_data=0x10..0x18 on 9 consecutive cycles with out_valid=1, then IDLE.
- Input gaps:
  - Stimulus: in_valid toggles 1,0,1,0 while 9 words 0xA0..0xA8 are sent.
  - Required: only the valid-cycle words are stored; send_done appears one cycle after the 9th valid word; output sequence is 0xA0..0xA8.
- Backpressure:
  - Stimulus: in DRAIN, out_ready=0 for 5 cycles at rd_ptr=3 (word 0x13).
  - Required: out_valid stays 1 and out_data stays 0x13 throughout; the sequence resumes at 0x14 when out_ready=1.
- Abort:
  - Stimulus: drop send_req after 4 words while in_valid=1.
  - Required: recv_abort=1 for one cycle; send_done never asserts; out_valid stays 0; the next full burst 0x20..0x28 is received correctly starting at wr_ptr=0.
- Back-to-back:
  - Stimulus: send_req held high through DRAIN.
  - Required: no RECV until one cycle after the last output transfer; the second burst data is intact.
- Reset:
  - Stimulus: rst=1 for 1 cycle during DRAIN at rd_ptr=5.
  - Required: next cycle out_valid=0 and send_done=0, state is IDLE, and no further words from the old burst are emitted.
